// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: line levels, data width and FSM encoding.
// The PARITY state exists only when UART_PARITY_EN is defined.
package uart_pkg;

    localparam int   DATA_W      = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clear is high so every frame starts on a fresh bit boundary.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic txclk,
    input  logic txreset,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge txclk or negedge txreset) begin
        if (!txreset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_frame_serializer.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Define UART_PARITY_EN to insert the even-parity bit between data and stop.
module uart_frame_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              txclk,
    input  logic              txreset,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        bit_cnt;
    logic              stop_cnt;
    logic              tick;
    logic              baud_clear;
    logic              last_stop;
    logic              accept;
`ifdef UART_PARITY_EN
    logic              parity_bit;
`endif

    // data_ready is only ever high in IDLE, so this is the full accept condition.
    assign accept     = data_valid && data_ready;
    assign baud_clear = (state == IDLE);
    assign last_stop  = (stop_cnt == 1'(STOP_BITS - 1));
    assign frame_done = (state == STOP) && last_stop && tick;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .txclk  (txclk),
        .txreset(txreset),
        .clear  (baud_clear),
        .tick   (tick)
    );

    always_ff @(posedge txclk or negedge txreset) begin
        if (!txreset) begin
            state      <= IDLE;
            txd        <= IDLE_LEVEL;
            busy       <= 1'b0;
            data_ready <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    data_ready <= 1'b1;
                    if (accept) begin
                        shreg      <= data;
                        bit_cnt    <= '0;
                        stop_cnt   <= 1'b0;
`ifdef UART_PARITY_EN
                        parity_bit <= ^data;
`endif
                        txd        <= START_LEVEL;
                        busy       <= 1'b1;
                        data_ready <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        txd   <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                            txd   <= parity_bit;
                            state <= PARITY;
`else
                            txd   <= IDLE_LEVEL;
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        txd   <= IDLE_LEVEL;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (last_stop) begin
                            busy       <= 1'b0;
                            data_ready <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    txd   <= IDLE_LEVEL;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_serializer.sv
// Bench for uart_frame_serializer: one instance with 1 stop bit, one with 2, both at 4 clocks per bit.
// Honours UART_PARITY_EN to expect the parity bit and the longer frame.
module tb_uart_frame_serializer;

`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME_A = 40 + 4 * P;
    localparam int FRAME_B = 44 + 4 * P;
    localparam int LOG_N   = 64;

    logic       txclk;
    logic       txreset;
    logic [7:0] data_a, data_b;
    logic       data_valid_a, data_valid_b;
    logic       data_ready_a, data_ready_b;
    logic       txd_a, txd_b;
    logic       busy_a, busy_b;
    logic       frame_done_a, frame_done_b;

    int checks = 0;
    int errors = 0;

    logic txd_log  [0:LOG_N-1];
    logic busy_log [0:LOG_N-1];
    logic done_log [0:LOG_N-1];
    logic rdy_log  [0:LOG_N-1];

    typedef struct {
        logic [7:0] d;
        logic       par;
    } vec_t;
    vec_t vecs [7];

    int   acc_at [2];
    int   acc_n;
    int   idle_cnt;
    int   high_cnt;
    logic acc_now;
    logic done_seen;

    uart_frame_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .txclk     (txclk),
        .txreset   (txreset),
        .data      (data_a),
        .data_valid(data_valid_a),
        .data_ready(data_ready_a),
        .txd       (txd_a),
        .busy      (busy_a),
        .frame_done(frame_done_a)
    );

    uart_frame_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
        .txclk     (txclk),
        .txreset   (txreset),
        .data      (data_b),
        .data_valid(data_valid_b),
        .data_ready(data_ready_b),
        .txd       (txd_b),
        .busy      (busy_b),
        .frame_done(frame_done_b)
    );

    initial txclk = 1'b0;
    always #5 txclk = ~txclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Waits (bounded) for data_ready, then offers one byte for exactly one clock.
    task automatic start_frame(input int which, input logic [7:0] d);
        int w = 0;
        @(negedge txclk);
        while (!(which != 0 ? data_ready_b : data_ready_a) && w < 200) begin
            @(negedge txclk);
            w++;
        end
        chk("ready_wait", 32'(w < 200), 32'd1);
        if (which != 0) begin
            data_b = d;
            data_valid_b = 1'b1;
        end else begin
            data_a = d;
            data_valid_a = 1'b1;
        end
        @(posedge txclk);
        #1;
        data_valid_a = 1'b0;
        data_valid_b = 1'b0;
    endtask

    // Logs outputs at each negedge; log[k] is the k-th cycle after the accept edge.
    // Optionally changes data and pulses data_valid mid-frame from cycle chg_cyc.
    task automatic capture(input int which, input int ncyc, input int chg_cyc, input logic [7:0] chg_d);
        for (int k = 0; k < LOG_N; k++) begin
            txd_log[k]  = 1'b0;
            busy_log[k] = 1'b0;
            done_log[k] = 1'b0;
            rdy_log[k]  = 1'b0;
        end
        for (int k = 1; k <= ncyc && k < LOG_N; k++) begin
            @(negedge txclk);
            txd_log[k]  = (which != 0) ? txd_b        : txd_a;
            busy_log[k] = (which != 0) ? busy_b       : busy_a;
            done_log[k] = (which != 0) ? frame_done_b : frame_done_a;
            rdy_log[k]  = (which != 0) ? data_ready_b : data_ready_a;
            if (chg_cyc != 0 && k == chg_cyc) begin
                if (which != 0) begin
                    data_b = chg_d;
                    data_valid_b = 1'b1;
                end else begin
                    data_a = chg_d;
                    data_valid_a = 1'b1;
                end
            end
            if (chg_cyc != 0 && k == chg_cyc + 4) begin
                data_valid_a = 1'b0;
                data_valid_b = 1'b0;
            end
        end
    endtask

    task automatic check_frame(input string name, input logic [12:0] exp_line, input int nbits, input int exp_done);
        logic [12:0] got = '0;
        int done_n = 0;
        int done_at = 0;
        for (int i = 0; i < nbits; i++) got[i] = txd_log[i * 4 + 2];
        for (int k = 1; k < LOG_N; k++) begin
            if (done_log[k]) begin
                done_n++;
                if (done_at == 0) done_at = k;
            end
        end
        chk({name, "_bits"}, 32'(got), 32'(exp_line));
        chk({name, "_done_at"}, done_at, exp_done);
        chk({name, "_done_pulses"}, done_n, 1);
        chk({name, "_busy_first"}, 32'(busy_log[1]), 32'd1);
        chk({name, "_busy_after"}, 32'(busy_log[exp_done + 1]), 32'd0);
        chk({name, "_ready_after"}, 32'(rdy_log[exp_done + 1]), 32'd1);
    endtask

    initial begin
        // Data bytes with their hand-computed even parity (XOR of the 8 bits).
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h01, 1'b1};
        vecs[5] = '{8'h80, 1'b1};
        vecs[6] = '{8'h3C, 1'b0};

        txreset      = 1'b0;
        data_a       = 8'h00;
        data_b       = 8'h00;
        data_valid_a = 1'b0;
        data_valid_b = 1'b0;

        // Reset state while held.
        #12;
        chk("reset_txd", 32'(txd_a), 32'd1);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_ready", 32'(data_ready_a), 32'd0);
        chk("reset_done", 32'(frame_done_a), 32'd0);
        chk("reset_ready_b", 32'(data_ready_b), 32'd0);
        @(negedge txclk);
        txreset = 1'b1;

        // Table of single frames on the 1-stop-bit instance.
        for (int i = 0; i < 7; i++) begin
            logic [12:0] exp_line;
`ifdef UART_PARITY_EN
            exp_line = {2'b00, 1'b1, vecs[i].par, vecs[i].d, 1'b0};
`else
            exp_line = {3'b000, 1'b1, vecs[i].d, 1'b0};
`endif
            start_frame(0, vecs[i].d);
            capture(0, FRAME_A + 2, 0, 8'h00);
            check_frame($sformatf("vec%0d", i), exp_line, 10 + P, FRAME_A);
        end

        // Back-to-back: valid held high, 8'h00 then 8'hFF.
        acc_n    = 0;
        idle_cnt = 0;
        data_a       = 8'h00;
        data_valid_a = 1'b1;
        @(negedge txclk);
        for (int k = 0; k < 200; k++) begin
            acc_now = data_ready_a && data_valid_a;
            if (acc_n == 1 && !busy_a) idle_cnt++;
            if (acc_now) begin
                acc_at[acc_n] = k;
                acc_n++;
            end
            if (acc_n == 2) break;
            @(posedge txclk);
            #1;
            if (acc_now) data_a = 8'hFF;
            @(negedge txclk);
        end
        chk("b2b_accepts", acc_n, 2);
        chk("b2b_gap", acc_at[1] - acc_at[0], FRAME_A + 1);
        chk("b2b_idle_cycles", idle_cnt, 1);
        @(posedge txclk);
        #1;
        data_valid_a = 1'b0;
        capture(0, FRAME_A + 2, 0, 8'h00);
`ifdef UART_PARITY_EN
        check_frame("b2b_ff", {2'b00, 1'b1, 1'b0, 8'hFF, 1'b0}, 10 + P, FRAME_A);
`else
        check_frame("b2b_ff", {3'b000, 1'b1, 8'hFF, 1'b0}, 10 + P, FRAME_A);
`endif

        // Two stop bits; data and valid disturbed mid-frame must not alter the byte.
        start_frame(1, 8'h5A);
        capture(1, FRAME_B + 2, 12, 8'hC3);
`ifdef UART_PARITY_EN
        check_frame("stop2", {1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0}, 11 + P, FRAME_B);
`else
        check_frame("stop2", {2'b00, 1'b1, 1'b1, 8'h5A, 1'b0}, 11 + P, FRAME_B);
`endif
        high_cnt = 0;
        for (int k = (9 + P) * 4 + 1; k <= (9 + P) * 4 + 8; k++) if (txd_log[k]) high_cnt++;
        chk("stop2_high_cycles", high_cnt, 8);
        chk("stop2_before_stop", 32'(txd_log[(9 + P) * 4]), 32'd0);

        // Asynchronous reset in the middle of DATA.
        start_frame(0, 8'h00);
        repeat (10) @(negedge txclk);
        chk("pre_reset_txd", 32'(txd_a), 32'd0);
        chk("pre_reset_busy", 32'(busy_a), 32'd1);
        #2;
        txreset = 1'b0;
        #1;
        chk("mid_reset_txd", 32'(txd_a), 32'd1);
        chk("mid_reset_busy", 32'(busy_a), 32'd0);
        chk("mid_reset_ready", 32'(data_ready_a), 32'd0);
        done_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge txclk);
            #1;
            if (frame_done_a) done_seen = 1'b1;
        end
        chk("mid_reset_ready_held", 32'(data_ready_a), 32'd0);
        @(negedge txclk);
        txreset = 1'b1;
        #1;
        chk("release_ready_before_clk", 32'(data_ready_a), 32'd0);
        @(posedge txclk);
        #1;
        chk("release_ready_first_clk", 32'(data_ready_a), 32'd1);
        chk("release_txd", 32'(txd_a), 32'd1);
        capture(0, 50, 0, 8'h00);
        for (int k = 1; k <= 50; k++) if (done_log[k]) done_seen = 1'b1;
        chk("abandoned_no_done", 32'(done_seen), 32'd0);
        chk("abandoned_idle_busy", 32'(busy_log[50]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_serializer.md
UART_FRAME_SERIALIZER -- requirements
Module: uart_frame_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning txclk cycles per serial bit period (legal 2..65535).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits per frame (legal 1 or 2).
REQ-003 SHALL have port txclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port txreset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port data, input, 8 bits: byte to transmit, sampled on accept.
REQ-006 SHALL have port data_valid, input, 1 bit: upstream offers data.
REQ-007 SHALL have port data_ready, output, 1 bit: block can accept a byte this cycle.
REQ-008 SHALL have port txd, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of the last stop bit.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL assert data_ready only in IDLE; accept occurs when data_valid && data_ready.
REQ-013 SHALL, on accept, latch data into an 8-bit shift register, clear the bit counter and baud counter, and enter START.
REQ-014 SHALL drive txd low from the cycle after accept for CLKS_PER_BIT cycles (START).
REQ-015 SHALL shift data LSB first in DATA, one bit per CLKS_PER_BIT cycles, for exactly 8 bits (3-bit counter, 7 -> exit).
REQ-016 SHALL, after DATA, enter PARITY when enabled (REQ-025), else STOP.
REQ-017 SHALL drive txd high for STOP_BITS*CLKS_PER_BIT cycles in STOP.
REQ-018 SHALL pulse frame_done for one cycle on the final STOP cycle and return to IDLE the next cycle.
REQ-019 SHALL hold txd high and busy low in IDLE; busy SHALL be high in all other states.
REQ-020 SHALL ignore data and data_valid changes while busy; the latched byte is not altered mid-frame.
REQ-021 SHALL guarantee at least one IDLE cycle between frames; back-to-back valid yields a frame period of (1 + 8 + P + STOP_BITS)*CLKS_PER_BIT + 1 cycles, where P = 1 with parity and 0 without.
REQ-022 SHALL use a baud counter of width clog2(CLKS_PER_BIT) that wraps from CLKS_PER_BIT-1 to 0, generating a bit-end tick.

Reset
REQ-023 SHALL, on txreset low, immediately (asynchronously) force state IDLE, txd=1, busy=0, frame_done=0, data_ready=0 while reset is held, and clear all counters and the shift register.
REQ-024 SHALL, on reset mid-frame, abandon the frame with no frame_done; data_ready SHALL rise on the first clock after release.

Configuration
REQ-025 SHALL honour macro UART_PARITY_EN: when defined, PARITY state exists and txd carries even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; when undefined, the PARITY state and logic are absent and DATA goes directly to STOP.

Structure
REQ-026 SHALL take the FSM state encoding and the constants IDLE_LEVEL=1, START_LEVEL=0, and DATA_W=8 from the shared package uart_pkg.
REQ-027 SHALL instantiate one sub-module, uart_baud_gen (parameter CLKS_PER_BIT; ports txclk, txreset, clear; output tick), for bit timing.

Verification
REQ-028 SHALL verify reset: txreset low mid-DATA -> txd=1, busy=0 asynchronously; no frame_done; data_ready=1 on the first clock after release.
REQ-029 SHALL verify a single frame: CLKS_PER_BIT=4, no parity, data=8'hA5 -> txd bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles; frame_done on cycle 40 after accept.
REQ-030 SHALL verify parity: UART_PARITY_EN, data=8'hA5 -> parity bit 0; data=8'h07 -> parity bit 1; frame is 44 cycles.
REQ-031 SHALL verify back-to-back: data_valid held high with 8'h00 then 8'hFF, CLKS_PER_BIT=4 -> accepts 41 cycles apart, exactly one IDLE cycle between frames.
REQ-032 SHALL verify stop bits and input stability: STOP_BITS=2, data changed mid-frame -> transmitted byte unchanged; txd high for 8 stop cycles.
